// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side master for a 1-cycle-latency FIFO.
// A start pulse requests a burst of burst_len words. The words are read from the
// FIFO, held in a 2-entry skid buffer, and forwarded on a valid/ready stream.
// done pulses for one cycle after the last word has been accepted downstream.
// Optional feature: define FIFO_BURST_READER_CHECKSUM_EN to add a `checksum`
// output holding the running XOR of the words delivered in the current burst.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  word_cnt
`ifdef FIFO_BURST_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_reg;
    logic [LEN_WIDTH-1:0]  len_reg;
    logic [LEN_WIDTH-1:0]  issued_reg;
    logic [LEN_WIDTH-1:0]  word_cnt_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  inflight_reg;
    logic [1:0]            buf_cnt_reg;
    logic [DATA_WIDTH-1:0] head_reg;
    logic [DATA_WIDTH-1:0] tail_reg;
    logic [2:0]            occupancy;
    logic                  xfer;
    logic                  start_ok;
    logic                  rd_en;

    assign out_valid = (buf_cnt_reg != 2'd0);
    assign out_data  = head_reg;
    assign xfer      = out_valid && out_ready;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign word_cnt  = word_cnt_reg;
    assign start_ok  = (state_reg == S_IDLE) && start && (burst_len != '0);

    // Words held or about to land in the skid buffer; the read in flight
    // already owns a slot, so it is counted here.
    assign occupancy = {1'b0, buf_cnt_reg} + {2'b00, inflight_reg};

    // Read issue: never on an empty FIFO, never past len, and only when a slot
    // is free now or is being freed by a downstream transfer this cycle.
    always_comb begin
        rd_en = 1'b0;
        if (state_reg == S_RUN && !fifo_empty && issued_reg < len_reg) begin
            if (occupancy < 3'd2) begin
                rd_en = 1'b1;
            end else if (occupancy == 3'd2 && xfer) begin
                rd_en = 1'b1;
            end
        end
    end

    assign fifo_read = rd_en;

    // Read tracking: in-flight flag mirrors last cycle's strobe, issued counts strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_reg <= 1'b0;
            issued_reg   <= '0;
        end else begin
            inflight_reg <= rd_en;
            if (start_ok) begin
                issued_reg <= '0;
            end else if (rd_en) begin
                issued_reg <= issued_reg + 1'b1;
            end
        end
    end

    // Skid buffer: head is always the oldest word; write and pop may coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            buf_cnt_reg <= 2'd0;
        end else begin
            case ({inflight_reg, xfer})
                2'b10: begin
                    if (buf_cnt_reg == 2'd0) begin
                        head_reg <= fifo_data_out;
                    end else begin
                        tail_reg <= fifo_data_out;
                    end
                    buf_cnt_reg <= buf_cnt_reg + 2'd1;
                end
                2'b01: begin
                    head_reg    <= tail_reg;
                    buf_cnt_reg <= buf_cnt_reg - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_reg == 2'd1) begin
                        head_reg <= fifo_data_out;
                    end else begin
                        head_reg <= tail_reg;
                        tail_reg <= fifo_data_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_BURST_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_reg;

    assign checksum = checksum_reg;

    // Running XOR of delivered words; frozen once the burst has drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_reg <= '0;
        end else if (start_ok) begin
            checksum_reg <= '0;
        end else if (xfer) begin
            checksum_reg <= checksum_reg ^ head_reg;
        end
    end
`endif

    // Burst control FSM with registered busy/done and delivered-word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            if (xfer && word_cnt_reg != len_reg) begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (start_ok) begin
                        len_reg      <= burst_len;
                        word_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issued_reg == len_reg) begin
                        state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (word_cnt_reg == len_reg && buf_cnt_reg == 2'd0) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
